// File: rtl/imem_boot_ram_pkg.sv
// Shared constants and types for the instruction memory and its boot-load sequencer.
package imem_boot_ram_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {BOOT_IDLE, BOOT_LOAD, BOOT_RUN} boot_state_t;

endpackage

// File: rtl/imem_boot_ram_dp_ram.sv
// Simple dual-port word array: one synchronous write port, one registered read port.
// No reset so the array and read register map onto block RAM.
module imem_dp_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4096,
   parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/imem_boot_ram.sv
// Instruction memory with boot-load sequencer: fills a region from a valid/ready
// word stream, then serves registered single-cycle fetches.
module imem_boot_ram
   import imem_boot_ram_pkg::*;
#(
   parameter int                 DATA_W   = 32,
   parameter int                 ADDR_W   = 12,
   parameter int                 DEPTH    = 4096,
   parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(imem_boot_ram_pkg::NOP_WORD)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_stall,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              fetch_fault,
   input  logic              boot_start,
   input  logic [ADDR_W-1:0] boot_base,
   input  logic [ADDR_W:0]   boot_len,
   input  logic              boot_valid,
   output logic              boot_ready,
   input  logic [DATA_W-1:0] boot_data,
   output logic              boot_busy,
   output logic              boot_done,
   output logic              boot_err,
   output logic [DATA_W-1:0] boot_csum
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_F = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W+1:0] DEPTH_B = (ADDR_W+2)'(DEPTH);

   boot_state_t state, state_nxt;

   logic [IDX_W-1:0]  wr_ptr;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W+1:0] end_addr;
   logic              range_bad, start_ok, accept, last_word;
   logic              in_range, run, fetch_ok, fetch_bad;
   logic [DATA_W-1:0] rdata;

   // Sum kept two bits wider than the address so base+len can never wrap.
   assign end_addr  = {2'b00, boot_base} + {1'b0, boot_len};
   assign range_bad = end_addr > DEPTH_B;
   assign start_ok  = boot_start && (state != BOOT_LOAD);
   assign accept    = (state == BOOT_LOAD) && boot_valid;
   assign last_word = accept && (remaining == (ADDR_W+1)'(1));
   assign run       = (state == BOOT_RUN);
   assign in_range  = {1'b0, fetch_addr} < DEPTH_F;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= BOOT_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         BOOT_IDLE, BOOT_RUN:
            if (start_ok && !range_bad)
               state_nxt = (boot_len == '0) ? BOOT_RUN : BOOT_LOAD;
         BOOT_LOAD:
            if (last_word) state_nxt = BOOT_RUN;
         default: state_nxt = BOOT_IDLE;
      endcase
   end

   always_comb begin
      boot_ready = 1'b0;
      boot_busy  = 1'b0;
      if (state == BOOT_LOAD) begin
         boot_ready = 1'b1;
         boot_busy  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         boot_done <= 1'b0;
         boot_err  <= 1'b0;
         boot_csum <= '0;
         wr_ptr    <= '0;
         remaining <= '0;
      end else if (start_ok) begin
         // A rejected start leaves the load bookkeeping untouched.
         boot_err  <= range_bad;
         boot_done <= !range_bad && (boot_len == '0);
         if (!range_bad) begin
            boot_csum <= '0;
            wr_ptr    <= boot_base[IDX_W-1:0];
            remaining <= boot_len;
         end
      end else if (accept) begin
         boot_csum <= boot_csum ^ boot_data;
         wr_ptr    <= wr_ptr + 1'b1;
         remaining <= remaining - 1'b1;
         if (last_word) boot_done <= 1'b1;
      end
   end

   // Fetch qualifiers share the stall enable with the RAM read register so all
   // three fetch outputs freeze together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_ok  <= 1'b0;
         fetch_bad <= 1'b0;
      end else if (!fetch_stall) begin
         fetch_ok  <= run && in_range;
         fetch_bad <= run && !in_range;
      end
   end

   imem_dp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (boot_data),
      .re    (!fetch_stall),
      .raddr (fetch_addr[IDX_W-1:0]),
      .rdata (rdata)
   );

   always_comb begin
      instr       = fetch_ok ? rdata : NOP_WORD;
      instr_valid = fetch_ok;
      fetch_fault = fetch_bad;
   end

endmodule

// File: tb/tb_imem_boot_ram.sv
// Scoreboard bench for imem_boot_ram: stimulus queues expected outputs, a monitor
// pops and compares them after each clock edge.
module tb_imem_boot_ram;
   import imem_boot_ram_pkg::*;

   localparam int DW = 32;
   localparam int AW = 13;
   localparam int DP = 4096;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] fetch_addr;
   logic          fetch_stall;
   logic [DW-1:0] instr;
   logic          instr_valid, fetch_fault;
   logic          boot_start;
   logic [AW-1:0] boot_base;
   logic [AW:0]   boot_len;
   logic          boot_valid, boot_ready;
   logic [DW-1:0] boot_data;
   logic          boot_busy, boot_done, boot_err;
   logic [DW-1:0] boot_csum;

   typedef struct {
      logic        cf;
      logic        cb;
      logic [31:0] instr;
      logic        v;
      logic        f;
      logic        rdy;
      logic        busy;
      logic        done;
      logic        err;
      logic [31:0] csum;
   } exp_t;

   exp_t pend;
   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   logic stim_done = 1'b0;

   logic [31:0] ld_w[4]  = '{32'hA, 32'hB, 32'hC, 32'hD};
   logic [31:0] ld_c[4]  = '{32'hA, 32'h1, 32'hD, 32'h0};
   logic        th_v[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [31:0] th_d[5]  = '{32'h100, 32'hDEAD, 32'hDEAD, 32'h200, 32'h400};
   logic [31:0] th_c[5]  = '{32'h100, 32'h100, 32'h100, 32'h300, 32'h700};

   imem_boot_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_addr  (fetch_addr),
      .fetch_stall (fetch_stall),
      .instr       (instr),
      .instr_valid (instr_valid),
      .fetch_fault (fetch_fault),
      .boot_start  (boot_start),
      .boot_base   (boot_base),
      .boot_len    (boot_len),
      .boot_valid  (boot_valid),
      .boot_ready  (boot_ready),
      .boot_data   (boot_data),
      .boot_busy   (boot_busy),
      .boot_done   (boot_done),
      .boot_err    (boot_err),
      .boot_csum   (boot_csum)
   );

   always #5 clk = ~clk;

   task automatic exp_f(input logic [31:0] i, input logic v, input logic f);
      pend.cf = 1'b1; pend.instr = i; pend.v = v; pend.f = f;
   endtask

   task automatic exp_b(input logic r, input logic b, input logic d, input logic e,
                        input logic [31:0] c);
      pend.cb = 1'b1; pend.rdy = r; pend.busy = b; pend.done = d; pend.err = e; pend.csum = c;
   endtask

   // Inputs are driven just after a falling edge; the next rising edge samples them
   // and the monitor checks the result on the following falling edge.
   task automatic tick();
      if (pend.cf || pend.cb) q.push_back(pend);
      pend.cf = 1'b0;
      pend.cb = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic fetch(input logic [AW-1:0] a, input logic [31:0] i);
      fetch_addr = a;
      exp_f(i, 1'b1, 1'b0);
      tick();
   endtask

   initial begin : monitor
      exp_t e;
      int   cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.cf) begin
               n_chk++;
               if (instr !== e.instr || instr_valid !== e.v || fetch_fault !== e.f) begin
                  n_fail++;
                  $display("FAIL fetch @%0t: got instr=%h valid=%b fault=%b, want instr=%h valid=%b fault=%b",
                           $time, instr, instr_valid, fetch_fault, e.instr, e.v, e.f);
               end
            end
            if (e.cb) begin
               n_chk++;
               if (boot_ready !== e.rdy || boot_busy !== e.busy || boot_done !== e.done ||
                   boot_err !== e.err || boot_csum !== e.csum) begin
                  n_fail++;
                  $display("FAIL boot @%0t: got rdy=%b busy=%b done=%b err=%b csum=%h, want rdy=%b busy=%b done=%b err=%b csum=%h",
                           $time, boot_ready, boot_busy, boot_done, boot_err, boot_csum,
                           e.rdy, e.busy, e.done, e.err, e.csum);
               end
            end
         end else if (stim_done) begin
            break;
         end
         if (cyc > 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got %0d cycles, want stimulus done within 2000", cyc);
            break;
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : stim
      pend = '{default: '0};
      rst_n = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
      boot_start = 1'b0; boot_base = '0; boot_len = '0; boot_valid = 1'b0; boot_data = '0;
      tick(); tick();
      exp_f(NOP, 1'b0, 1'b0); exp_b(0, 0, 0, 0, 32'h0); tick();
      rst_n = 1'b1;
      exp_f(NOP, 1'b0, 1'b0); exp_b(0, 0, 0, 0, 32'h0); tick();

      // back-to-back load of 4 words at base 0
      boot_start = 1'b1; boot_base = 0; boot_len = 4;
      exp_b(1, 1, 0, 0, 32'h0); tick();
      boot_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         boot_valid = 1'b1; boot_data = ld_w[i];
         exp_b(i < 3, i < 3, i == 3, 0, ld_c[i]); tick();
      end
      boot_valid = 1'b0;
      fetch(2, 32'hC); fetch(0, 32'hA); fetch(3, 32'hD);

      // throttled load, with an ignored start in the middle
      boot_start = 1'b1; boot_base = 16; boot_len = 3;
      exp_b(1, 1, 0, 0, 32'h0); tick();
      boot_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         boot_valid = th_v[i]; boot_data = th_d[i];
         boot_start = (i == 2);
         if (i == 2) begin boot_base = 100; boot_len = 2; end
         exp_b(i < 4, i < 4, i == 4, 0, th_c[i]);
         exp_f(NOP, 1'b0, 1'b0); tick();
      end
      boot_start = 1'b0; boot_valid = 1'b0;
      fetch(16, 32'h100); fetch(17, 32'h200); fetch(18, 32'h400);

      // zero-length load completes immediately
      boot_start = 1'b1; boot_base = 5; boot_len = 0;
      exp_b(0, 0, 1, 0, 32'h0); tick();

      // out-of-range start is rejected; state stays RUN and nothing is written
      boot_base = 4090; boot_len = 8; boot_valid = 1'b1; boot_data = 32'hBAD;
      exp_b(0, 0, 0, 1, 32'h0); tick();
      boot_start = 1'b0; boot_valid = 1'b0;
      fetch_addr = 16; exp_f(32'h100, 1'b1, 1'b0); exp_b(0, 0, 0, 1, 32'h0); tick();
      fetch_addr = 4096; exp_f(NOP, 1'b0, 1'b1); tick();
      fetch_addr = 8191; exp_f(NOP, 1'b0, 1'b1); tick();

      // last implemented word exactly fills to DEPTH
      boot_start = 1'b1; boot_base = 4095; boot_len = 1;
      exp_b(1, 1, 0, 0, 32'h0); tick();
      boot_start = 1'b0; boot_valid = 1'b1; boot_data = 32'h77;
      exp_b(0, 0, 1, 0, 32'h77); tick();
      boot_valid = 1'b0;
      fetch(4095, 32'h77);

      // stall holds the previous fetch result
      fetch(1, 32'hB);
      fetch_stall = 1'b1;
      fetch(3, 32'hB); fetch(3, 32'hB);
      fetch_stall = 1'b0;
      fetch(3, 32'hD);

      // reset in the middle of a load, then a short reload
      boot_start = 1'b1; boot_base = 0; boot_len = 4;
      exp_b(1, 1, 0, 0, 32'h0); tick();
      boot_start = 1'b0; boot_valid = 1'b1; boot_data = 32'h11;
      exp_b(1, 1, 0, 0, 32'h11); tick();
      boot_data = 32'h22;
      exp_b(1, 1, 0, 0, 32'h33); tick();
      boot_valid = 1'b0; rst_n = 1'b0;
      exp_b(0, 0, 0, 0, 32'h0); exp_f(NOP, 1'b0, 1'b0); tick();
      rst_n = 1'b1; fetch_addr = 0;
      exp_f(NOP, 1'b0, 1'b0); tick();
      boot_start = 1'b1; boot_base = 0; boot_len = 1;
      exp_b(1, 1, 0, 0, 32'h0); tick();
      boot_start = 1'b0; boot_valid = 1'b1; boot_data = 32'h55;
      exp_b(0, 0, 1, 0, 32'h55); tick();
      boot_valid = 1'b0;
      fetch(0, 32'h55); fetch(1, 32'h22); fetch(2, 32'hC);

      stim_done = 1'b1;
   end

endmodule
